// File: rtl/led_matrix_frame_ctrl_if.sv
// Host-side register bus of the LED matrix frame controller: row writes,
// swap request/pending handshake and the PWM brightness setting.
interface led_matrix_frame_ctrl_if #(
   parameter int PWM_BITS = 4
);
   logic                wr_en;
   logic [2:0]          wr_row;
   logic [7:0]          wr_data;
   logic                swap_req;
   logic [PWM_BITS-1:0] brightness;
   logic                swap_pending;

   modport master (
      output wr_en, wr_row, wr_data, swap_req, brightness,
      input  swap_pending
   );

   modport slave (
      input  wr_en, wr_row, wr_data, swap_req, brightness,
      output swap_pending
   );
endinterface

// File: rtl/led_matrix_frame_ctrl.sv
// Double-buffered 8x8 frame store with frame-aligned swap and frame-granular
// PWM output enable for the row/column scan driver.

// One matrix row: host-written back byte plus the displayed front byte.
module led_matrix_row_cell (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_sel,
   input  logic [7:0] wr_data,
   input  logic       swap,
   output logic [7:0] front_row
);
   logic [7:0] back_q, back_d;
   logic [7:0] front_q, front_d;

   // The copy takes the pre-edge back byte, so a same-edge write lands only in back.
   always_comb begin
      back_d  = wr_sel ? wr_data : back_q;
      front_d = swap ? back_q : front_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         back_q  <= '0;
         front_q <= '0;
      end else begin
         back_q  <= back_d;
         front_q <= front_d;
      end
   end

   assign front_row = front_q;
endmodule

module led_matrix_frame_ctrl #(
   parameter int PWM_BITS = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   led_matrix_frame_ctrl_if.slave  hif,
   output logic                    frame_start,
   output logic [63:0]             disp_data,
   output logic                    disp_oe
);
   localparam int NUM_ROWS = 8;
   localparam int ROW_W    = 8;

   logic [2:0]          phase_q, phase_d;
   logic                pend_q, pend_d;
   logic [PWM_BITS-1:0] fcnt_q, fcnt_d;
   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic                oe_q, oe_d;
   logic                fs_q, fs_d;
   logic                boundary;
   logic                swap_now;

   logic [NUM_ROWS-1:0]            wr_sel;
   logic [NUM_ROWS-1:0][ROW_W-1:0] front_rows;

   assign boundary = (phase_q == 3'd7);
   assign swap_now = boundary && pend_q;

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign wr_sel[r] = hif.wr_en && (hif.wr_row == 3'(r));

      led_matrix_row_cell u_row (
         .clock     (clock),
         .reset     (reset),
         .wr_sel    (wr_sel[r]),
         .wr_data   (hif.wr_data),
         .swap      (swap_now),
         .front_row (front_rows[r])
      );
   end

   always_comb begin
      phase_d  = phase_q + 3'd1;
      fs_d     = (phase_d == 3'd0);
      pend_d   = pend_q;
      fcnt_d   = fcnt_q;
      bright_d = bright_q;
      oe_d     = oe_q;

      // A boundary with a pending swap retires it even if swap_req is high again.
      if (swap_now)
         pend_d = 1'b0;
      else if (hif.swap_req)
         pend_d = 1'b1;

      if (boundary) begin
         fcnt_d = fcnt_q + 1'b1;
         if (fcnt_d == '0)
            bright_d = hif.brightness;
         // Post-edge values so a newly latched brightness rules frame 0 of its period.
         oe_d = (fcnt_d < bright_d);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q  <= 3'd0;
         pend_q   <= 1'b0;
         fcnt_q   <= '0;
         bright_q <= '0;
         oe_q     <= 1'b0;
         fs_q     <= 1'b1;
      end else begin
         phase_q  <= phase_d;
         pend_q   <= pend_d;
         fcnt_q   <= fcnt_d;
         bright_q <= bright_d;
         oe_q     <= oe_d;
         fs_q     <= fs_d;
      end
   end

   assign hif.swap_pending = pend_q;
   assign frame_start      = fs_q;
   assign disp_data        = front_rows;
   assign disp_oe          = oe_q;
endmodule

// File: tb/tb_led_matrix_frame_ctrl.sv
// Directed bench for led_matrix_frame_ctrl: reset, write/swap, PWM duty,
// boundary collisions and brightness latching.
module tb_led_matrix_frame_ctrl;
   logic        clock = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [63:0] disp_data;
   logic        disp_oe;

   int total = 0;
   int bad   = 0;
   int ph    = 0;
   int fc    = 0;

   led_matrix_frame_ctrl_if #(.PWM_BITS(4)) hif ();

   led_matrix_frame_ctrl #(.PWM_BITS(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .hif         (hif),
      .frame_start (frame_start),
      .disp_data   (disp_data),
      .disp_oe     (disp_oe)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock; tb phase/frame counters mirror the elapsed edges since release.
   task automatic step();
      @(posedge clock);
      #1;
      if (ph == 7) fc = (fc + 1) % 16;
      ph = (ph + 1) % 8;
   endtask

   task automatic goto_pstart();
      int n = 0;
      do begin
         step();
         n++;
      end while (!(ph == 0 && fc == 0) && n < 300);
      chk("pstart_frame_start", frame_start, 1'b1);
   endtask

   // One full PWM period from its start: lit clocks, first dark clock, in-frame oe changes.
   task automatic measure(output int hi, output int first_low, output int changes);
      logic prev;
      hi = 0; first_low = 128; changes = 0; prev = disp_oe;
      for (int i = 0; i < 128; i++) begin
         if (disp_oe) hi++;
         else if (first_low == 128) first_low = i;
         if (ph != 0 && disp_oe !== prev) changes++;
         prev = disp_oe;
         step();
      end
   endtask

   initial begin
      int hi, fl, ch, cnt, n;
      reset = 1'b1;
      hif.wr_en = 1'b0; hif.wr_row = 3'd0; hif.wr_data = 8'h00;
      hif.swap_req = 1'b0; hif.brightness = 4'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_oe", disp_oe, 1'b0);
      chk("rst_data", disp_data, 64'h0);
      chk("rst_pend", hif.swap_pending, 1'b0);
      chk("rst_fs", frame_start, 1'b1);
      reset = 1'b0; ph = 0; fc = 0;

      repeat (7) step();
      chk("fs_ph7", frame_start, 1'b0);
      step();
      chk("fs_first_boundary", frame_start, 1'b1);

      // Write rows 0..7 then request a swap accepted on the edge into phase 3.
      for (int r = 0; r < 8; r++) begin
         hif.wr_en = 1'b1; hif.wr_row = r[2:0]; hif.wr_data = 8'(1 << r);
         step();
      end
      hif.wr_en = 1'b0;
      while (ph != 2) step();
      hif.swap_req = 1'b1;
      step();
      hif.swap_req = 1'b0;
      cnt = 0;
      while (hif.swap_pending && cnt < 12) begin
         if (ph == 7) chk("pre_swap_data", disp_data, 64'h0);
         cnt++;
         step();
      end
      chk("pend_cycles", 64'(cnt), 64'd5);
      chk("swap_data", disp_data, 64'h8040201008040201);
      chk("swap_at_boundary", frame_start, 1'b1);

      // PWM duty at brightness 5 over four periods.
      hif.brightness = 4'd5;
      goto_pstart();
      for (int p = 0; p < 4; p++) begin
         measure(hi, fl, ch);
         chk("b5_hi", 64'(hi), 64'd40);
         chk("b5_first_low", 64'(fl), 64'd40);
         chk("b5_in_frame_changes", 64'(ch), 64'd0);
      end

      hif.brightness = 4'd0;
      goto_pstart();
      measure(hi, fl, ch);
      chk("b0_hi", 64'(hi), 64'd0);

      hif.brightness = 4'hF;
      goto_pstart();
      measure(hi, fl, ch);
      chk("bF_hi", 64'(hi), 64'd120);
      chk("bF_first_low", 64'(fl), 64'd120);

      // Brightness change three frames into a period waits for the next period.
      hif.brightness = 4'd5;
      goto_pstart();
      hi = 0;
      for (int i = 0; i < 128; i++) begin
         if (i == 24) hif.brightness = 4'd12;
         if (disp_oe) hi++;
         step();
      end
      chk("mid_change_cur", 64'(hi), 64'd40);
      measure(hi, fl, ch);
      chk("mid_change_next", 64'(hi), 64'd96);
      chk("mid_change_first_low", 64'(fl), 64'd96);

      // swap_req plus a row-2 write on a boundary edge while idle.
      while (ph != 7) step();
      chk("coll_pend_before", hif.swap_pending, 1'b0);
      hif.swap_req = 1'b1; hif.wr_en = 1'b1; hif.wr_row = 3'd2; hif.wr_data = 8'hAA;
      step();
      hif.swap_req = 1'b0; hif.wr_en = 1'b0;
      chk("coll_pend_set", hif.swap_pending, 1'b1);
      chk("coll_no_swap", disp_data, 64'h8040201008040201);
      repeat (8) step();
      chk("coll_swap_data", disp_data, 64'h8040201008AA0201);
      chk("coll_pend_clr", hif.swap_pending, 1'b0);

      // Repeated requests while pending, including one on the boundary edge.
      hif.wr_en = 1'b1; hif.wr_row = 3'd0; hif.wr_data = 8'h55;
      step();
      hif.wr_en = 1'b0;
      n = 0;
      while (ph != 0 && n < 10) begin
         hif.swap_req = (ph % 2 == 1);
         step();
         n++;
      end
      hif.swap_req = 1'b0;
      chk("rep_swap_data", disp_data, 64'h8040201008AA0255);
      chk("rep_pend_clr", hif.swap_pending, 1'b0);
      repeat (8) step();
      chk("rep_no_second", hif.swap_pending, 1'b0);

      // Asynchronous reset mid-frame during a lit frame.
      n = 0;
      while (!(disp_oe && ph == 5) && n < 300) begin
         step();
         n++;
      end
      chk("lit_before_reset", disp_oe, 1'b1);
      reset = 1'b1;
      #1;
      chk("arst_oe", disp_oe, 1'b0);
      chk("arst_data", disp_data, 64'h0);
      chk("arst_pend", hif.swap_pending, 1'b0);
      chk("arst_fs", frame_start, 1'b1);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0; ph = 0; fc = 0;
      repeat (7) step();
      chk("arst_fs_ph7", frame_start, 1'b0);
      step();
      chk("arst_first_boundary", frame_start, 1'b1);
      ph = 0; fc = 1;
      hi = 0;
      for (int i = 0; i < 120; i++) begin
         if (disp_oe) hi++;
         step();
      end
      chk("arst_first_period_dark", 64'(hi), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_matrix_frame_ctrl.md
# led_matrix_frame_ctrl

Frame controller for the 8x8 LED matrix scan driver. It holds a double-buffered 64-bit frame image written row-by-row by the host, presents the front buffer to the driver's `data` input, and drives the driver's `oe`. It swaps buffers only on scan-frame boundaries and applies frame-granular PWM brightness. It sits between the MCU-side register interface and the 64-bit row/column scan driver.

## Interface

Parameters:
- `PWM_BITS`, default 4: width of the brightness value and the PWM frame counter. The PWM period is 2^PWM_BITS frames.

Ports:
- `clock`  in  1: sole clock, rising edge; the same clock that drives the scan driver.
- `reset`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write strobe for the back buffer, one row per cycle.
- `wr_row`  in  3: row index for the write.
- `wr_data`  in  8: column bits for the row being written.
- `swap_req`  in  1: single-cycle request to copy the back buffer to the front buffer at the next frame boundary.
- `brightness`  in  PWM_BITS: number of lit frames per PWM period.
- `swap_pending`  out  1: high from acceptance of `swap_req` until the swap has completed.
- `frame_start`  out  1: high during phase 0 of every frame.
- `disp_data`  out  64: front buffer; connects to the driver's `data`.
- `disp_oe`  out  1: connects to the driver's `oe`.

## Operation

- **Phase counter** `phase[2:0]`:
  - Increments every clock and wraps 7->0.
  - A frame is 8 clocks.
  - The boundary edge is the edge where `phase` goes 7->0.
- **Back buffer write:** `wr_en`=1 writes `back[8*wr_row +: 8]` <= `wr_data` on that edge. Writes are accepted every cycle, with no back-pressure.
- **Swap:**
  - `swap_req`=1 sets `swap_pending` on that edge.
  - On a boundary edge with `swap_pending`=1: `front` <= `back` (value before the edge), and `swap_pending` is cleared.
  - `swap_req` while already pending has no further effect; one swap results.
  - If `swap_req` arrives on a boundary edge while not pending, it sets pending and the swap occurs at the following boundary.
  - A write on a boundary edge updates `back` but is not part of a copy made on that edge.
- **PWM:**
  - `fcnt[PWM_BITS-1:0]` increments on each boundary edge and wraps.
  - `bright_q` latches `brightness` on the boundary edge where `fcnt` wraps to 0.
  - Registered `disp_oe`, updated only on boundary edges, is set to (next `fcnt` < next `bright_q`). The compare uses post-edge values so the latch takes effect in the same frame.
  - Brightness 0 gives permanently dark; the maximum value gives (2^PWM_BITS - 1) lit frames per period.
- **Driver alignment:**
  - The driver clears its row select whenever `oe`=0.
  - `disp_oe` is 0 out of reset and changes only at boundaries, so the driver's row select always equals `phase` during lit frames.
  - `disp_data` and `disp_oe` are constant across all 8 cycles of a frame.
- **`frame_start`:** registered, equals (`phase`==0).

## Timing

- **Reset values:**
  - `phase`=0, `fcnt`=0, `bright_q`=0.
  - `back`=0 and `front`=0, so `disp_data`=64'h0.
  - `disp_oe`=0, `swap_pending`=0, `frame_start`=1 (phase 0).
- **Reset mid-frame** aborts immediately. Outputs take reset values asynchronously and the driver blanks on its next edge.
- **First lit frame** after reset occurs no earlier than the first boundary edge, 8 clocks after reset release.
- **Write latency:**
  - `back` updates on the write edge.
  - The write is visible on `disp_data` after the next swap boundary that follows both the write and a `swap_req`.
- **Swap latency:** from `swap_req` edge to `front` update is 1 to 8 clocks, landing exactly on a boundary edge.
- **Brightness change latency:** takes effect at the next PWM period start, up to 8·2^PWM_BITS clocks.
- **`disp_oe`** has no glitches; it toggles only on boundary edges.
- **Driver output lag:** LED row/column outputs lag `disp_oe`/`disp_data` by one clock, which is the driver register.

## Test plan

- **Reset:** assert `reset` mid-frame at phase 5 -> `disp_oe`=0, `disp_data`=0, `swap_pending`=0 immediately; the first boundary occurs 8 clocks after release.
- **Write and swap:** write rows 0..7 with 8'h01, 8'h02, ..., 8'h80, then pulse `swap_req` at phase 3 -> `swap_pending` is high for 5 cycles, then `disp_data`=64'h8040201008040201 from the boundary edge onward.
- **PWM:** `brightness`=4'd5, run 64 frames -> exactly 5 lit frames per 16-frame period. `disp_oe` is high for 40 consecutive clocks, then low for 88. Each lit frame drives the driver rows 1,2,4,...,128 in order.
- **Brightness extremes:** `brightness`=0 -> `disp_oe` never rises. `brightness`=4'hF -> 15 lit frames and 1 dark frame per period.
- **Boundary collisions:**
  - `swap_req` and `wr_en` (row 2, 8'hAA) asserted on a boundary edge with pending=0 -> no swap at that edge; the swap at the next boundary includes 8'hAA in `disp_data[23:16]`.
  - Repeated `swap_req` pulses while pending -> one swap.
- **Mid-period brightness change:** change `brightness` 5->12 at frame 3 of a period -> the current period still has 5 lit frames; the next period has 12.
